// File: rtl/security_mode_ctrl_if.sv
// Signal bundle between the home-security front panel/sensors and the mode controller.
// The master side drives buttons, code switches and sensors; the slave side returns mode, message and alarm.
interface security_mode_ctrl_if;
  logic       btn_arm_stay;
  logic       btn_arm_away;
  logic       btn_disarm;
  logic       btn_set;
  logic       btn_show;
  logic [3:0] sw_code;
  logic       sensor_door;
  logic       sensor_motion;
  logic [2:0] mode;
  logic [3:0] msg;
  logic       alarm;
  logic [2:0] fail_cnt;

  modport master (
    output btn_arm_stay, btn_arm_away, btn_disarm, btn_set, btn_show,
    output sw_code, sensor_door, sensor_motion,
    input  mode, msg, alarm, fail_cnt
  );

  modport slave (
    input  btn_arm_stay, btn_arm_away, btn_disarm, btn_set, btn_show,
    input  sw_code, sensor_door, sensor_motion,
    output mode, msg, alarm, fail_cnt
  );
endinterface

// File: rtl/security_mode_ctrl.sv
// Home-security control FSM: synchronizes buttons/sensors, manages passcode, arming, alarm and timed messages.
// Optional door entry delay in away mode is enabled by defining SEC_ENTRY_DELAY_EN.
module security_mode_ctrl #(
  parameter int unsigned MSG_CYCLES   = 50_000_000,
  parameter int unsigned ENTRY_CYCLES = 500_000_000,
  parameter int unsigned MAX_FAILS    = 3,
  parameter logic [3:0]  DEFAULT_CODE = 4'b0000
) (
  input logic                 clk,
  input logic                 rst_n,
  security_mode_ctrl_if.slave bus
);

  // Timer is sized for the longer of the two dwell periods so both builds share one width.
  localparam int unsigned TMR_MAX = (MSG_CYCLES > ENTRY_CYCLES) ? MSG_CYCLES : ENTRY_CYCLES;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] MODE_UNARM = 3'b000;
  localparam logic [2:0] MODE_ARMS  = 3'b001;
  localparam logic [2:0] MODE_ARMA  = 3'b010;
  localparam logic [2:0] MODE_RESET = 3'b011;
  localparam logic [2:0] MODE_DISP  = 3'b100;

  typedef enum logic [2:0] {
    S_UNARMED,
    S_ARMED_STAY,
    S_ARMED_AWAY,
    S_ALARM,
    S_MSG_RESET,
    S_MSG_SHOW
`ifdef SEC_ENTRY_DELAY_EN
    , S_ENTRY
`endif
  } state_t;

  state_t             state_q;
  logic [2:0]         mode_q;
  logic [3:0]         msg_q;
  logic               alarm_q;
  logic [2:0]         fail_q;
  logic [2:0]         fail_d;
  logic [3:0]         code_q;
  logic [TMR_W-1:0]   tmr_q;

  logic [6:0] raw;
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;
  logic [4:0] prev_q;
  logic [4:0] evt;
  logic       win_stay, win_away, win_disarm, win_set, win_show;
  logic       door, motion, eq;

  assign raw = {bus.sensor_motion, bus.sensor_door, bus.btn_show, bus.btn_set,
                bus.btn_disarm, bus.btn_arm_away, bus.btn_arm_stay};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[4:0];
    end
  end

  // Rising-edge events on the synced buttons; only the highest-priority one may act.
  always_comb begin
    evt        = sync2_q[4:0] & ~prev_q;
    win_disarm = evt[2];
    win_away   = evt[1] & ~evt[2];
    win_stay   = evt[0] & ~evt[1] & ~evt[2];
    win_set    = evt[3] & ~(|evt[2:0]);
    win_show   = evt[4] & ~(|evt[3:0]);
    door       = sync2_q[5];
    motion     = sync2_q[6];
    eq         = (bus.sw_code == code_q);
    fail_d     = (fail_q >= 3'(MAX_FAILS)) ? fail_q : fail_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_UNARMED;
      mode_q  <= MODE_UNARM;
      msg_q   <= '0;
      alarm_q <= 1'b0;
      fail_q  <= '0;
      code_q  <= DEFAULT_CODE;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        S_UNARMED: begin
          if (win_away && eq) begin
            state_q <= S_ARMED_AWAY;
            mode_q  <= MODE_ARMA;
            fail_q  <= '0;
          end else if (win_stay && eq) begin
            state_q <= S_ARMED_STAY;
            mode_q  <= MODE_ARMS;
            fail_q  <= '0;
          end else if (win_set) begin
            code_q  <= bus.sw_code;
            state_q <= S_MSG_RESET;
            mode_q  <= MODE_RESET;
            tmr_q   <= TMR_W'(MSG_CYCLES - 1);
          end else if (win_show) begin
            state_q <= S_MSG_SHOW;
            mode_q  <= MODE_DISP;
            msg_q   <= code_q;
            tmr_q   <= TMR_W'(MSG_CYCLES - 1);
          end
        end
        S_MSG_RESET, S_MSG_SHOW: begin
          if (tmr_q == '0) begin
            state_q <= S_UNARMED;
            mode_q  <= MODE_UNARM;
            msg_q   <= '0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          // Armed, alarm and entry states: disarm wins over any same-cycle sensor trip.
          if (win_disarm) begin
            if (eq) begin
              state_q <= S_UNARMED;
              mode_q  <= MODE_UNARM;
              alarm_q <= 1'b0;
              fail_q  <= '0;
            end else begin
              fail_q <= fail_d;
              if (fail_d >= 3'(MAX_FAILS)) begin
                state_q <= S_ALARM;
                alarm_q <= 1'b1;
              end
            end
          end else if ((state_q == S_ARMED_STAY && door) ||
                       (state_q == S_ARMED_AWAY && motion)) begin
            state_q <= S_ALARM;
            alarm_q <= 1'b1;
          end else if (state_q == S_ARMED_AWAY && door) begin
`ifdef SEC_ENTRY_DELAY_EN
            state_q <= S_ENTRY;
            tmr_q   <= TMR_W'(ENTRY_CYCLES - 1);
`else
            state_q <= S_ALARM;
            alarm_q <= 1'b1;
`endif
          end
`ifdef SEC_ENTRY_DELAY_EN
          else if (state_q == S_ENTRY) begin
            if (tmr_q == '0) begin
              state_q <= S_ALARM;
              alarm_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

  assign bus.mode     = mode_q;
  assign bus.msg      = msg_q;
  assign bus.alarm    = alarm_q;
  assign bus.fail_cnt = fail_q;

endmodule
